// File: rtl/adder_pool_arbiter_pkg.sv
// rtl/adder_pool_arbiter_pkg.sv - shared id-width helper and in-flight tag record
package adder_pool_arbiter_pkg;

  // Tag ids are sized for the largest supported pool (8 requesters).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fully_pipelined_adder.sv
// rtl/fully_pipelined_adder.sv - bit-serial pipelined adder, one result bit per stage
// Latency is WIDTH cycles; operands shift down as their low bits are consumed (WIDTH >= 2).
module fully_pipelined_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_stage
    localparam int IW = WIDTH - k;
    logic [IW-1:0] a_in, b_in;
    logic          c_in, s_bit;
    logic [IW-2:0] a_q, b_q;
    logic [k:0]    s_q;
    logic          c_q;

    if (k == 0) begin : g_head
      assign a_in = a_i;
      assign b_in = b_i;
      assign c_in = cin_i;
      always_ff @(posedge clk_i) if (en_i) s_q <= s_bit;
    end else begin : g_body
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign c_in = g_stage[k-1].c_q;
      always_ff @(posedge clk_i) if (en_i) s_q <= {s_bit, g_stage[k-1].s_q};
    end

    assign s_bit = a_in[0] ^ b_in[0] ^ c_in;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        a_q <= a_in[IW-1:1];
        b_q <= b_in[IW-1:1];
        c_q <= (a_in[0] & b_in[0]) | (c_in & (a_in[0] ^ b_in[0]));
      end
    end
  end

  logic             a_l, b_l, c_l;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign a_l = g_stage[WIDTH-2].a_q[0];
  assign b_l = g_stage[WIDTH-2].b_q[0];
  assign c_l = g_stage[WIDTH-2].c_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      sum_q  <= {a_l ^ b_l ^ c_l, g_stage[WIDTH-2].s_q};
      cout_q <= (a_l & b_l) | (c_l & (a_l ^ b_l));
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/adder_pool_arbiter.sv
// rtl/adder_pool_arbiter.sv - round-robin credit-limited arbiter around one shared pipelined adder
module adder_pool_arbiter
  import adder_pool_arbiter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic [clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int IDW = clog2(NREQ);
  localparam int CW  = clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  CAP  = CW'(MAX_OUT);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [IDW-1:0]   ptr_q, ptr_d, winner;
  logic             grant;
  logic [CW-1:0]    out_q [NREQ];
  logic [CW-1:0]    out_d [NREQ];
  tag_t             tag_q [WIDTH];
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             rsp_valid_q, rsp_cout_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;

  always_comb begin
    int idx;
    grant  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant && !rst && req_valid[idx] && (out_q[idx] < CAP)) begin
        grant  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign ptr_d = !grant ? ptr_q : (winner == LAST) ? '0 : winner + 1'b1;

  // The operand mux follows the winner even without a grant; the tag marks those slots dead.
  assign add_a   = req_a[winner*WIDTH +: WIDTH];
  assign add_b   = req_b[winner*WIDTH +: WIDTH];
  assign add_cin = req_cin[winner];

  fully_pipelined_adder #(.WIDTH(WIDTH)) u_adder (
    .clk_i  (clk),
    .en_i   (1'b1),
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // A credit returns on the edge the result is loaded into the output register.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      inc      = grant && (winner == IDW'(i));
      dec      = tag_q[WIDTH-1].valid && (tag_q[WIDTH-1].id == ID_MAX_W'(i));
      out_d[i] = out_q[i];
      if (inc && !dec)      out_d[i] = out_q[i] + 1'b1;
      else if (dec && !inc) out_d[i] = out_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      for (int i = 0; i < NREQ; i++) out_q[i] <= '0;
      for (int k = 0; k < WIDTH; k++) tag_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < NREQ; i++) out_q[i] <= out_d[i];
      tag_q[0].valid <= grant;
      tag_q[0].id    <= ID_MAX_W'(winner);
      for (int k = 1; k < WIDTH; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= tag_q[WIDTH-1].valid;
      if (tag_q[WIDTH-1].valid) begin
        rsp_id_q   <= tag_q[WIDTH-1].id[IDW-1:0];
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
      end
    end
  end

  always_comb begin
    busy = rsp_valid_q;
    for (int k = 0; k < WIDTH; k++) busy = busy | tag_q[k].valid;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_pool_arbiter.sv
// tb/tb_adder_pool_arbiter.sv - scoreboard bench for adder_pool_arbiter
module tb_adder_pool_arbiter;

  localparam int WIDTH   = 4;
  localparam int NREQ    = 4;
  localparam int MAX_OUT = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_cin, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_cout, busy;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;

  typedef struct {
    int id;
    int sum;
    int cout;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   exp_sum [NREQ];
  int   exp_cout[NREQ];
  int   glog_id[$], glog_edge[$], glog_rsp[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   st, cnt;

  adder_pool_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int cin,
                        input int s, input int co);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_cin[i]              = cin[0];
    exp_sum[i]              = s;
    exp_cout[i]             = co;
  endtask

  task automatic pulse(input logic [NREQ-1:0] mask, input int n, output int start);
    @(posedge clk);
    #1;
    start     = cyc;
    req_valid = mask;
    repeat (n) @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic clear_log();
    glog_id.delete();
    glog_edge.delete();
    glog_rsp.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", int'(sb.size() != 0 || busy), 0);
  endtask

  task automatic check_grant(input string name, input int k, input int id, input int edge_no);
    if (k < glog_id.size()) begin
      check({name, "_id"}, glog_id[k], id);
      check({name, "_edge"}, glog_edge[k], edge_no);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", int'(rsp_id), e.id);
          check("rsp_sum", int'(rsp_sum), e.sum);
          check("rsp_cout", int'(rsp_cout), e.cout);
          check("rsp_latency", cyc, e.due);
        end
      end
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        check("ready_subset", int'(req_ready & ~req_valid), 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, exp_sum[i], exp_cout[i], cyc + 1 + WIDTH});
          glog_id.push_back(i);
          glog_edge.push_back(cyc + 1);
          glog_rsp.push_back(int'(rsp_valid));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(req_ready), 0);
    check("reset_sum", int'(rsp_sum), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    // all four requesters continuously valid
    set_op(0, 3, 4, 0, 7, 0);
    set_op(1, 15, 15, 1, 15, 1);
    set_op(2, 8, 8, 0, 0, 1);
    set_op(3, 6, 9, 0, 15, 0);
    clear_log();
    pulse(4'b1111, 8, st);
    check("rr_count", glog_id.size(), 8);
    for (int k = 0; k < 8; k++) check_grant("rr", k, k % 4, st + 1 + k);
    drain();

    // single op from requester 2
    set_op(2, 9, 8, 1, 2, 1);
    clear_log();
    pulse(4'b0100, 1, st);
    check("single_count", glog_id.size(), 1);
    check_grant("single", 0, 2, st + 1);
    drain();
    check("hold_valid", int'(rsp_valid), 0);
    check("hold_id", int'(rsp_id), 2);
    check("hold_sum", int'(rsp_sum), 2);
    check("hold_cout", int'(rsp_cout), 1);

    // pointer sits at 3: requester 3 then wrap to 0
    set_op(3, 15, 0, 1, 0, 1);
    set_op(0, 7, 5, 0, 12, 0);
    clear_log();
    pulse(4'b1001, 2, st);
    check("wrap_count", glog_id.size(), 2);
    check_grant("wrap0", 0, 3, st + 1);
    check_grant("wrap1", 1, 0, st + 2);
    drain();

    // credit cap on a lone requester
    set_op(1, 5, 6, 0, 11, 0);
    clear_log();
    pulse(4'b0010, 10, st);
    check("cap_count", glog_id.size(), 4);
    check_grant("cap0", 0, 1, st + 1);
    check_grant("cap1", 1, 1, st + 2);
    check_grant("cap2", 2, 1, st + 6);
    check_grant("cap3", 3, 1, st + 7);
    if (glog_rsp.size() == 4) begin
      check("cap0_rsp", glog_rsp[0], 0);
      check("cap2_rsp", glog_rsp[2], 1);
      check("cap3_rsp", glog_rsp[3], 1);
    end
    drain();

    // reset with three ops in flight
    set_op(0, 1, 2, 0, 3, 0);
    set_op(1, 4, 4, 0, 8, 0);
    set_op(2, 14, 1, 1, 0, 1);
    clear_log();
    pulse(4'b0111, 3, st);
    check("flight_count", glog_id.size(), 3);
    check_grant("flight0", 0, 2, st + 1);
    #1;
    rst       = 1'b1;
    req_valid = '1;
    #1;
    check("arst_rsp_valid", int'(rsp_valid), 0);
    check("arst_rsp_id", int'(rsp_id), 0);
    check("arst_rsp_sum", int'(rsp_sum), 0);
    check("arst_rsp_cout", int'(rsp_cout), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ready", int'(req_ready), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;
    cnt       = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(rsp_valid);
    end
    check("post_reset_quiet", cnt, 0);
    set_op(3, 12, 3, 0, 15, 0);
    clear_log();
    pulse(4'b1000, 1, st);
    check("post_reset_count", glog_id.size(), 1);
    check_grant("post_reset", 0, 3, st + 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
